// File: rtl/pll_drp_seq.sv
// DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes a stored
// table of DRP registers, releases reset and waits for lock, with DRDY/lock timeouts.
module pll_drp_seq #(
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        start,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_idx,
    input  logic [6:0]  cfg_addr,
    input  logic [15:0] cfg_mask,
    input  logic [15:0] cfg_data,
    input  logic [3:0]  cfg_count,
    input  logic [15:0] DO,
    input  logic        DRDY,
    input  logic        LOCKED,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    output logic        DEN,
    output logic        DWE,
    output logic        PLL_RST,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int unsigned MAX_TO = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned CW     = $clog2(MAX_TO + 1);
    localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, RST_ASSERT, RD, RD_WAIT, WR, WR_WAIT, NEXT, RST_RELEASE, LOCK_WAIT, FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  count_q, count_d;
    logic [6:0]  tbl_addr_q [8];
    logic [6:0]  tbl_addr_d [8];
    logic [15:0] tbl_mask_q [8];
    logic [15:0] tbl_mask_d [8];
    logic [15:0] tbl_data_q [8];
    logic [15:0] tbl_data_d [8];
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic        pll_rst_q, pll_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        ptr_d      = ptr_q;
        count_d    = count_q;
        tbl_addr_d = tbl_addr_q;
        tbl_mask_d = tbl_mask_q;
        tbl_data_d = tbl_data_q;
        daddr_d    = daddr_q;
        di_d       = di_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;

        if (cfg_we && !busy_q) begin
            tbl_addr_d[cfg_idx] = cfg_addr;
            tbl_mask_d[cfg_idx] = cfg_mask;
            tbl_data_d[cfg_idx] = cfg_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_count == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = RST_ASSERT;
                        error_d    = 1'b0;
                        err_code_d = 2'd0;
                        count_d    = (cfg_count > 4'd8) ? 4'd8 : cfg_count;
                        ptr_d      = '0;
                    end
                end
            end
            RST_ASSERT: begin
                state_d = RD;
                daddr_d = tbl_addr_q[ptr_q[2:0]];
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                if (DRDY) begin
                    di_d    = (DO & tbl_mask_q[ptr_q[2:0]]) |
                              (tbl_data_q[ptr_q[2:0]] & ~tbl_mask_q[ptr_q[2:0]]);
                    state_d = WR;
                end else if (cnt_q == DRDY_LAST) begin
                    state_d    = FAIL;
                    error_d    = 1'b1;
                    err_code_d = 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: state_d = WR_WAIT;
            WR_WAIT: begin
                if (DRDY) begin
                    state_d = NEXT;
                end else if (cnt_q == DRDY_LAST) begin
                    state_d    = FAIL;
                    error_d    = 1'b1;
                    err_code_d = 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_d < count_q) begin
                    state_d = RD;
                    daddr_d = tbl_addr_q[ptr_d[2:0]];
                end else begin
                    state_d = RST_RELEASE;
                end
            end
            RST_RELEASE: state_d = LOCK_WAIT;
            LOCK_WAIT: begin
                if (LOCKED) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d    = FAIL;
                    error_d    = 1'b1;
                    err_code_d = 2'd2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAIL: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with state_q.
        den_d     = (state_d == RD) || (state_d == WR);
        dwe_d     = (state_d == WR);
        pll_rst_d = (state_d == RST_ASSERT) || (state_d == RD) || (state_d == RD_WAIT) ||
                    (state_d == WR) || (state_d == WR_WAIT) || (state_d == NEXT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge DCLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            daddr_q    <= '0;
            di_q       <= '0;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            pll_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_mask_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            pll_rst_q  <= pll_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            tbl_addr_q <= tbl_addr_d;
            tbl_mask_q <= tbl_mask_d;
            tbl_data_q <= tbl_data_d;
        end
    end

    assign DADDR    = daddr_q;
    assign DI       = di_q;
    assign DEN      = den_q;
    assign DWE      = dwe_q;
    assign PLL_RST  = pll_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_pll_drp_seq.sv
// Bench for pll_drp_seq: DRP register model plus PLL lock model, with a scoreboard of
// expected DRP transactions that is checked on every DEN pulse.
module tb_pll_drp_seq;

    logic        DCLK = 1'b0;
    logic        RST, start, cfg_we;
    logic [2:0]  cfg_idx;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask, cfg_data;
    logic [3:0]  cfg_count;
    logic [15:0] DO;
    logic        DRDY, LOCKED;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic        DEN, DWE, PLL_RST, busy, done, error;
    logic [1:0]  err_code;

    pll_drp_seq #(.DRDY_TIMEOUT(64), .LOCK_TIMEOUT(100)) dut (
        .DCLK(DCLK), .RST(RST), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .DO(DO), .DRDY(DRDY), .LOCKED(LOCKED), .DADDR(DADDR), .DI(DI), .DEN(DEN), .DWE(DWE),
        .PLL_RST(PLL_RST), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 DCLK = ~DCLK;

    typedef struct packed {
        logic [6:0]  addr;
        logic        we;
        logic [15:0] di;
    } txn_t;

    txn_t        exp_q[$];
    int          n_err = 0;
    int          n_chk = 0;
    int          den_cnt = 0;
    logic [15:0] mem    [128];
    logic [15:0] shadow [128];
    logic [6:0]  m_addr [8];
    logic [15:0] m_mask [8];
    logic [15:0] m_data [8];
    logic [15:0] last_di;
    bit          drdy_en = 1'b1;
    int          drdy_lat = 1;
    int          lock_mode = 2;   // 0: held low, 1: rises 10 cycles after release, 2: held high
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DRP register model: DRDY arrives drdy_lat cycles after the DEN cycle
    int          pend = 0;
    logic        s_den, s_dwe;
    logic [6:0]  s_addr;
    logic [15:0] s_di, rd_val;
    initial begin
        DRDY = 1'b0;
        DO = '0;
        rd_val = '0;
        forever begin
            @(posedge DCLK);
            s_den = DEN; s_dwe = DWE; s_addr = DADDR; s_di = DI;
            #1;
            DRDY = 1'b0;
            if (s_den === 1'b1) begin
                if (s_dwe) mem[s_addr] = s_di;
                else rd_val = mem[s_addr];
                pend = drdy_lat;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    DRDY = drdy_en;
                    DO = rd_val;
                end
            end
        end
    end

    int   lcnt = 0;
    logic s_prst;
    initial begin
        LOCKED = 1'b1;
        forever begin
            @(posedge DCLK);
            s_prst = PLL_RST;
            #1;
            case (lock_mode)
                0: LOCKED = 1'b0;
                1: begin
                    if (s_prst === 1'b1) begin
                        lcnt = 0;
                        LOCKED = 1'b0;
                    end else if (!LOCKED) begin
                        lcnt++;
                        if (lcnt >= 10) LOCKED = 1'b1;
                    end
                end
                default: LOCKED = 1'b1;
            endcase
        end
    end

    // Scoreboard: every DEN pulse pops one expected transaction
    txn_t t_mon;
    initial begin
        forever begin
            @(negedge DCLK);
            if (mon_en) begin
                if (DEN === 1'b1) begin
                    den_cnt++;
                    check("pll_rst_during_drp", PLL_RST, 1);
                    if (exp_q.size() == 0) begin
                        check("den_expected", DEN & (exp_q.size() > 0), 1);
                    end else begin
                        t_mon = exp_q.pop_front();
                        check("daddr", DADDR, t_mon.addr);
                        check("dwe", DWE, t_mon.we);
                        if (t_mon.we) check("di", DI, t_mon.di);
                    end
                end else begin
                    check("dwe_without_den", DWE, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [6:0] a, input logic [15:0] m,
                             input logic [15:0] d, input bit model);
        cfg_we = 1'b1; cfg_idx = idx[2:0]; cfg_addr = a; cfg_mask = m; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        if (model) begin
            m_addr[idx] = a; m_mask[idx] = m; m_data[idx] = d;
        end
    endtask

    task automatic push_seq(input int cnt);
        for (int i = 0; i < cnt && i < 8; i++) begin
            txn_t t;
            logic [15:0] v;
            t.addr = m_addr[i]; t.we = 1'b0; t.di = '0;
            exp_q.push_back(t);
            v = (shadow[m_addr[i]] & m_mask[i]) | (m_data[i] & ~m_mask[i]);
            shadow[m_addr[i]] = v;
            t.we = 1'b1; t.di = v;
            exp_q.push_back(t);
            last_di = v;
        end
    endtask

    // Pulses start and returns the number of edges until done or error is seen
    task automatic run(input logic [3:0] cnt, input int limit, output int n);
        start = 1'b1;
        cfg_count = cnt;
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (n == 1) start = 1'b0;
            if (done === 1'b1 || error === 1'b1) break;
        end
        check("run_terminated", done | error, 1);
    endtask

    int n, d0;
    txn_t t0;

    initial begin
        RST = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0;
        cfg_mask = '0; cfg_data = '0; cfg_count = '0;
        for (int a = 0; a < 128; a++) begin
            mem[a] = 16'hA500 ^ 16'(a);
            shadow[a] = mem[a];
        end
        mem[8] = 16'h1234;
        shadow[8] = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            m_addr[i] = '0; m_mask[i] = '0; m_data[i] = '0;
        end

        repeat (3) tick();
        check("rst_den", DEN, 0);
        check("rst_dwe", DWE, 0);
        check("rst_daddr", DADDR, 0);
        check("rst_di", DI, 0);
        check("rst_pll_rst", PLL_RST, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        RST = 1'b0;
        mon_en = 1'b1;
        tick();

        // single entry read-modify-write, lock arrives 10 cycles after release
        lock_mode = 1;
        cfg_write(0, 7'h08, 16'h1000, 16'h0041, 1);
        push_seq(1);
        d0 = den_cnt;
        run(1, 200, n);
        check("t1_done", done, 1);
        check("t1_error", error, 0);
        check("t1_den_pulses", den_cnt - d0, 2);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_di_value", last_di, 16'h1041);
        tick();
        check("t1_done_one_cycle", done, 0);
        check("t1_busy_idle", busy, 0);

        // three entries at minimum latency
        lock_mode = 2;
        cfg_write(1, 7'h14, 16'hFF00, 16'h00A5, 1);
        cfg_write(2, 7'h4E, 16'h0000, 16'hC3C3, 1);
        push_seq(3);
        d0 = den_cnt;
        run(3, 200, n);
        check("t2_latency", n, 19);
        check("t2_den_pulses", den_cnt - d0, 6);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_daddr_hold", DADDR, 7'h4E);
        check("t2_di_hold", DI, last_di);

        // DRDY never arrives
        drdy_en = 1'b0;
        t0.addr = 7'h08; t0.we = 1'b0; t0.di = '0;
        exp_q.push_back(t0);
        run(1, 200, n);
        check("t3_fail_cycle", n, 67);
        check("t3_done", done, 0);
        check("t3_error", error, 1);
        check("t3_err_code", err_code, 1);
        check("t3_pll_rst", PLL_RST, 0);
        tick();
        check("t3_busy_idle", busy, 0);
        check("t3_error_sticky", error, 1);
        check("t3_queue_empty", exp_q.size(), 0);
        drdy_en = 1'b1;

        // lock never arrives, then a clean retry
        lock_mode = 0;
        push_seq(1);
        run(1, 300, n);
        check("t4_fail_cycle", n, 108);
        check("t4_error", error, 1);
        check("t4_err_code", err_code, 2);
        tick();
        check("t4_busy_idle", busy, 0);
        lock_mode = 2;
        push_seq(1);
        run(1, 200, n);
        check("t4_retry_latency", n, 9);
        check("t4_retry_done", done, 1);
        check("t4_retry_error", error, 0);
        check("t4_retry_err_code", err_code, 0);
        check("t4_queue_empty", exp_q.size(), 0);

        // zero-count start, then table write and restart attempts while busy
        d0 = den_cnt;
        run(0, 10, n);
        check("t5_zero_latency", n, 1);
        check("t5_zero_pll_rst", PLL_RST, 0);
        check("t5_zero_busy", busy, 0);
        repeat (4) tick();
        check("t5_zero_den", den_cnt - d0, 0);
        push_seq(1);
        d0 = den_cnt;
        start = 1'b1; cfg_count = 4'd1;
        tick();
        start = 1'b0;
        n = 1;
        cfg_write(0, 7'h33, 16'h0000, 16'hDEAD, 0);
        n++;
        start = 1'b1; cfg_count = 4'd3;
        tick();
        start = 1'b0;
        n++;
        while (n < 100 && done !== 1'b1) begin
            tick();
            n++;
        end
        check("t5_busy_latency", n, 9);
        repeat (20) tick();
        check("t5_no_restart", den_cnt - d0, 2);
        check("t5_busy_idle", busy, 0);
        push_seq(1);
        run(1, 200, n);
        check("t5_table_kept_done", done, 1);
        check("t5_queue_empty", exp_q.size(), 0);

        // reset during WR_WAIT with a late DRDY outstanding
        drdy_lat = 3;
        push_seq(1);
        start = 1'b1; cfg_count = 4'd1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            start = 1'b0;
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t6_den", DEN, 0);
        check("t6_dwe", DWE, 0);
        check("t6_daddr", DADDR, 0);
        check("t6_di", DI, 0);
        check("t6_pll_rst", PLL_RST, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_error", error, 0);
        check("t6_err_code", err_code, 0);
        for (int i = 0; i < 8; i++) begin
            m_addr[i] = '0; m_mask[i] = '0; m_data[i] = '0;
        end
        d0 = den_cnt;
        repeat (6) tick();
        check("t6_late_drdy_busy", busy, 0);
        check("t6_late_drdy_den", den_cnt - d0, 0);
        check("t6_late_drdy_done", done, 0);
        check("t6_queue_empty", exp_q.size(), 0);
        drdy_lat = 1;
        push_seq(1);
        run(1, 200, n);
        check("t6_cleared_table_done", done, 1);
        check("t6_cleared_table_di", last_di, 0);
        check("t6_final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
